// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS main control: states, opcodes,
// ALU operation codes and the packed control word driven to the datapath.
package mc_ctrl_pkg;

  typedef enum logic [3:0] {
    S_IDLE    = 4'd0,
    S_FETCH   = 4'd1,
    S_DECODE  = 4'd2,
    S_MEMADR  = 4'd3,
    S_MEMRD   = 4'd4,
    S_MEMWB   = 4'd5,
    S_MEMWR   = 4'd6,
    S_EXEC    = 4'd7,
    S_RWB     = 4'd8,
    S_BRANCH  = 4'd9,
    S_JUMP    = 4'd10,
    S_ADDI_EX = 4'd11,
    S_ADDI_WB = 4'd12
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_B    = 2'b00;
  localparam logic [1:0] SRCB_4    = 2'b01;
  localparam logic [1:0] SRCB_SEXT = 2'b10;
  localparam logic [1:0] SRCB_SHL2 = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_source;
  } ctrl_t;

  // States that wait on the memory handshake and run the wait counter.
  function automatic logic is_mem_state(state_t s);
    return (s == S_FETCH) || (s == S_MEMRD) || (s == S_MEMWR);
  endfunction

endpackage

// File: rtl/mc_ctrl_outdec.sv
// Moore output decode: state (plus mem_ready for the FETCH IR/PC load) to
// control word. ADDI states decode only when MC_ADDI_EN is defined.
module mc_ctrl_outdec
  import mc_ctrl_pkg::*;
(
  input  state_t i_state,
  input  logic   i_mem_ready,
  output ctrl_t  o_ctrl
);

  always_comb begin
    o_ctrl = '0;
    case (i_state)
      S_FETCH: begin
        o_ctrl.mem_read  = 1'b1;
        o_ctrl.alu_src_b = SRCB_4;
        o_ctrl.alu_op    = ALUOP_ADD;
        o_ctrl.pc_source = PCSRC_ALU;
        o_ctrl.ir_write  = i_mem_ready;
        o_ctrl.pc_write  = i_mem_ready;
      end
      S_DECODE: begin
        o_ctrl.alu_src_b = SRCB_SHL2;
        o_ctrl.alu_op    = ALUOP_ADD;
      end
      S_MEMADR: begin
        o_ctrl.alu_src_a = 1'b1;
        o_ctrl.alu_src_b = SRCB_SEXT;
        o_ctrl.alu_op    = ALUOP_ADD;
      end
      S_MEMRD: begin
        o_ctrl.mem_read = 1'b1;
        o_ctrl.iord     = 1'b1;
      end
      S_MEMWB: begin
        o_ctrl.reg_write  = 1'b1;
        o_ctrl.mem_to_reg = 1'b1;
      end
      S_MEMWR: begin
        o_ctrl.mem_write = 1'b1;
        o_ctrl.iord      = 1'b1;
      end
      S_EXEC: begin
        o_ctrl.alu_src_a = 1'b1;
        o_ctrl.alu_src_b = SRCB_B;
        o_ctrl.alu_op    = ALUOP_FUNCT;
      end
      S_RWB: begin
        o_ctrl.reg_write = 1'b1;
        o_ctrl.reg_dst   = 1'b1;
      end
      S_BRANCH: begin
        o_ctrl.alu_src_a     = 1'b1;
        o_ctrl.alu_src_b     = SRCB_B;
        o_ctrl.alu_op        = ALUOP_SUB;
        o_ctrl.pc_write_cond = 1'b1;
        o_ctrl.pc_source     = PCSRC_ALUOUT;
      end
      S_JUMP: begin
        o_ctrl.pc_write  = 1'b1;
        o_ctrl.pc_source = PCSRC_JUMP;
      end
`ifdef MC_ADDI_EN
      S_ADDI_EX: begin
        o_ctrl.alu_src_a = 1'b1;
        o_ctrl.alu_src_b = SRCB_SEXT;
        o_ctrl.alu_op    = ALUOP_ADD;
      end
      S_ADDI_WB: begin
        o_ctrl.reg_write = 1'b1;
      end
`endif
      default: o_ctrl = '0;
    endcase
  end

endmodule

// File: rtl/mc_main_control.sv
// Multi-cycle MIPS main control FSM with mem_ready stall and wait timeout.
// Define MC_ADDI_EN to make opcode 001000 (addi) a legal instruction.
module mc_main_control
  import mc_ctrl_pkg::*;
#(
  parameter int STATE_W     = 4,
  parameter int MEM_TIMEOUT = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [5:0]         opcode,
  input  logic               mem_ready,
  output logic               pc_write,
  output logic               pc_write_cond,
  output logic               iord,
  output logic               mem_read,
  output logic               mem_write,
  output logic               ir_write,
  output logic               mem_to_reg,
  output logic               reg_dst,
  output logic               reg_write,
  output logic               alu_src_a,
  output logic [1:0]         alu_src_b,
  output logic [1:0]         alu_op,
  output logic [1:0]         pc_source,
  output logic               illegal_op,
  output logic               mem_err,
  output logic [STATE_W-1:0] state_o
);

  localparam int CNT_W = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] C_LAST = (MEM_TIMEOUT > 0) ? CNT_W'(MEM_TIMEOUT - 1) : '0;

  state_t           r_state;
  state_t           w_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic             w_timeout;
  logic             w_illegal;
  ctrl_t            w_ctrl;

  // With MEM_TIMEOUT=0 the counter simply wraps; the compare is disabled.
  assign w_timeout = (MEM_TIMEOUT > 0) && is_mem_state(r_state) &&
                     !mem_ready && (r_cnt == C_LAST);

  always_comb begin
    w_nxt     = r_state;
    w_illegal = 1'b0;
    case (r_state)
      S_IDLE:   w_nxt = S_FETCH;
      S_FETCH:  if (mem_ready) w_nxt = S_DECODE;
      S_DECODE: begin
        case (opcode)
          OP_LW, OP_SW: w_nxt = S_MEMADR;
          OP_RTYPE:     w_nxt = S_EXEC;
          OP_BEQ:       w_nxt = S_BRANCH;
          OP_J:         w_nxt = S_JUMP;
`ifdef MC_ADDI_EN
          OP_ADDI:      w_nxt = S_ADDI_EX;
`endif
          default: begin
            w_illegal = 1'b1;
            w_nxt     = S_FETCH;
          end
        endcase
      end
      S_MEMADR: w_nxt = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD:  if (mem_ready) w_nxt = S_MEMWB;
                else if (w_timeout) w_nxt = S_FETCH;
      S_MEMWB:  w_nxt = S_FETCH;
      S_MEMWR:  if (mem_ready || w_timeout) w_nxt = S_FETCH;
      S_EXEC:   w_nxt = S_RWB;
      S_RWB:    w_nxt = S_FETCH;
      S_BRANCH: w_nxt = S_FETCH;
      S_JUMP:   w_nxt = S_FETCH;
`ifdef MC_ADDI_EN
      S_ADDI_EX: w_nxt = S_ADDI_WB;
      S_ADDI_WB: w_nxt = S_FETCH;
`endif
      default:  w_nxt = S_IDLE;
    endcase
  end

  // A FETCH timeout loops back into FETCH, so it must clear the counter too.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_nxt;
      if ((w_nxt != r_state) || w_timeout) r_cnt <= '0;
      else if (is_mem_state(r_state) && !mem_ready) r_cnt <= r_cnt + 1'b1;
    end
  end

  mc_ctrl_outdec u_outdec (
    .i_state     (r_state),
    .i_mem_ready (mem_ready),
    .o_ctrl      (w_ctrl)
  );

  assign pc_write      = w_ctrl.pc_write;
  assign pc_write_cond = w_ctrl.pc_write_cond;
  assign iord          = w_ctrl.iord;
  assign mem_read      = w_ctrl.mem_read;
  assign mem_write     = w_ctrl.mem_write;
  assign ir_write      = w_ctrl.ir_write;
  assign mem_to_reg    = w_ctrl.mem_to_reg;
  assign reg_dst       = w_ctrl.reg_dst;
  assign reg_write     = w_ctrl.reg_write;
  assign alu_src_a     = w_ctrl.alu_src_a;
  assign alu_src_b     = w_ctrl.alu_src_b;
  assign alu_op        = w_ctrl.alu_op;
  assign pc_source     = w_ctrl.pc_source;
  assign illegal_op    = w_illegal;
  assign mem_err       = w_timeout;
  assign state_o       = STATE_W'(r_state);

endmodule
